data_sram_responder: RTL

- Responder (slave) end of the CPU data-SRAM request/response interface; the MEM stage sits on the receiving side of the same interface.
- Accepts requests (req/addr_ok handshake), performs writes into an internal word array, and returns in-order responses (data_ok/rdata) a fixed LATENCY after acceptance.
- Supports up to DEPTH outstanding requests.
- Used as the data memory model for pipeline bring-up and for verifying MEM-stage stall/flush behaviour before the AXI bridge exists.

---
 rtl/data_sram_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-SRAM responder: word memory with fixed-latency in-order responses
// Optional DATA_SRAM_RESP_RAND_EN: LFSR-driven pseudo-random accept stalls.
module data_sram_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         data_sram_req,
  input  logic                         data_sram_wr,
  input  logic [1:0]                   data_sram_size,
  input  logic [31:0]                  data_sram_addr,
  input  logic [3:0]                   data_sram_wstrb,
  input  logic [31:0]                  data_sram_wdata,
  output logic                         data_sram_addr_ok,
  output logic                         data_sram_data_ok,
  output logic [31:0]                  data_sram_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]      mem_q [0:(1<<AW)-1];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       cnt_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic          full;
  logic          accept;
  logic          pop;
  logic [AW-1:0] idx;
  logic [31:0]   snap_word;
  logic          unused_bits;

  // size and the non-indexing address bits never influence behaviour
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  assign idx  = data_sram_addr[AW+1:2];
  assign full = (count_q == CW'(DEPTH));

`ifdef DATA_SRAM_RESP_RAND_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign data_sram_addr_ok = ~full & lfsr_q[0];
`else
  assign data_sram_addr_ok = ~full;
`endif

  assign accept = data_sram_req & data_sram_addr_ok;
  assign pop    = valid_q[rd_ptr_q] & (cnt_q[rd_ptr_q] == 4'd0);

  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = pop ? data_q[rd_ptr_q] : 32'd0;
  assign outstanding_cnt   = count_q;

  // read snapshot is taken before this cycle's write lands
  assign snap_word = data_sram_wr ? 32'd0 : mem_q[idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cnt_q[i] != 4'd0) cnt_q[i] <= cnt_q[i] - 4'd1;
      end
      if (pop) valid_q[rd_ptr_q] <= 1'b0;
      // a slot being filled is never the one popping: that would need a full queue
      if (accept) begin
        valid_q[wr_ptr_q] <= 1'b1;
        data_q[wr_ptr_q]  <= snap_word;
        cnt_q[wr_ptr_q]   <= CNT_INIT;
      end
    end
  end

endmodule
